exec_sequencer: RTL and testbench

Parametrised successor to the current execution engine: fetches instruction bundles from instruction memory, unpacks them into fixed-width instructions, stages operands from main memory into the matrix or integer ALU over the shared address/data bus, waits on an explicit ALU completion handshake, and writes results back to main memory. It sits as the sole bus master between instruction memory, main memory, and both ALUs. Compared with the current engine, it adds:

- configurable bundle and operand widths;
- ALU done/timeout handling;
- illegal-opcode skipping;
- a halted state in place of simulation stop.

---
 rtl/exec_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Purpose: sole bus master that fetches instruction bundles, stages operands into the matrix/int ALU, waits for AluDone, writes results back.
// Latency: 2 cycles per bundle fetch; 8 cycles per legal instruction (+1 per extra WAIT cycle); 2 per illegal; timeout after TIMEOUT WAIT cycles.
// Backpressure: AluDone is the only handshake. Memories are fixed 1-cycle read latency. The engine parks in HALT on STOP or timeout.
// Ports: Clk/nReset; InstructDataOut, MemDataOut, MatrixDataOut, IntDataOut, AluDone in;
//        ExeDataOut, address, opcode, nRead, nWrite, Halted, IllegalOp, TimedOut, RetireCount out.
module exec_sequencer #(
  parameter int DATA_W  = 256,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 16,
  parameter int SEL_W   = 4,
  parameter int INT_W   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic [DATA_W-1:0] InstructDataOut,
  input  logic [DATA_W-1:0] MemDataOut,
  input  logic [DATA_W-1:0] MatrixDataOut,
  input  logic [DATA_W-1:0] IntDataOut,
  input  logic              AluDone,
  output logic [DATA_W-1:0] ExeDataOut,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        opcode,
  output logic              nRead,
  output logic              nWrite,
  output logic              Halted,
  output logic              IllegalOp,
  output logic              TimedOut,
  output logic [15:0]       RetireCount
);

  localparam int SLOTS  = DATA_W / INSTR_W;
  localparam int F_W    = INSTR_W / 4;
  localparam int OFF_W  = ADDR_W - SEL_W;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SEL_W-1:0]  SEL_MAIN  = SEL_W'(0);
  localparam logic [SEL_W-1:0]  SEL_INSTR = SEL_W'(1);
  localparam logic [SEL_W-1:0]  SEL_MAT   = SEL_W'(2);
  localparam logic [SEL_W-1:0]  SEL_INT   = SEL_W'(3);
  localparam logic [DATA_W-1:0] INT_MASK  = DATA_W'({INT_W{1'b1}});

  typedef enum logic [3:0] {
    S_FETCH, S_LATCH, S_DECODE, S_RD_A, S_RD_B,
    S_WR_A, S_WR_B, S_WAIT, S_WB, S_NEXT, S_HALT
  } state_t;

  state_t             state;
  logic [OFF_W-1:0]   bundle;
  logic [SLOT_W-1:0]  slot;
  logic [DATA_W-1:0]  slot_buf;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  result;
  logic [F_W-1:0]     r_dest;
  logic [F_W-1:0]     r_src2;
  logic               r_int;
  logic               r_imm;
  logic [CNT_W-1:0]   wait_cnt;

  // Current slot selected out of the latched bundle; slot 0 is the low word.
  logic [INSTR_W-1:0] cur_instr;
  always_comb begin
    cur_instr = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot == SLOT_W'(i)) cur_instr = slot_buf[i*INSTR_W +: INSTR_W];
    end
  end

  logic [F_W-1:0] f_op, f_dest, f_src1, f_src2;
  assign f_op   = cur_instr[4*F_W-1 -: F_W];
  assign f_dest = cur_instr[3*F_W-1 -: F_W];
  assign f_src1 = cur_instr[2*F_W-1 -: F_W];
  assign f_src2 = cur_instr[F_W-1:0];

  logic is_mat, is_int, is_stop;
  assign is_mat  = (f_op <= F_W'(5));
  assign is_int  = (f_op >= F_W'(16)) && (f_op <= F_W'(19));
  assign is_stop = (f_op == F_W'(255));

  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] a_drv, b_drv;
  assign alu_sel = r_int ? SEL_INT : SEL_MAT;
  assign a_drv   = r_int ? (op_a & INT_MASK) : op_a;
  // MScaleImm sends its src2 field as the scalar instead of the second operand.
  assign b_drv   = r_imm ? DATA_W'(r_src2) : (r_int ? (op_b & INT_MASK) : op_b);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state       <= S_FETCH;
      bundle      <= '0;
      slot        <= '0;
      slot_buf    <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      r_dest      <= '0;
      r_src2      <= '0;
      r_int       <= 1'b0;
      r_imm       <= 1'b0;
      wait_cnt    <= '0;
      ExeDataOut  <= '0;
      address     <= '0;
      opcode      <= '0;
      nRead       <= 1'b1;
      nWrite      <= 1'b1;
      Halted      <= 1'b0;
      IllegalOp   <= 1'b0;
      TimedOut    <= 1'b0;
      RetireCount <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          address <= {SEL_INSTR, bundle};
          nRead   <= 1'b0;
          nWrite  <= 1'b1;
          state   <= S_LATCH;
        end
        S_LATCH: begin
          slot_buf <= InstructDataOut;
          slot     <= '0;
          nRead    <= 1'b1;
          address  <= '0;
          state    <= S_DECODE;
        end
        S_DECODE: begin
          opcode     <= 8'(f_op);
          r_dest     <= f_dest;
          r_src2     <= f_src2;
          r_int      <= is_int;
          r_imm      <= (f_op == F_W'(5));
          ExeDataOut <= '0;
          if (is_stop) begin
            nRead   <= 1'b1;
            address <= '0;
            state   <= S_HALT;
          end else if (!is_mat && !is_int) begin
            IllegalOp <= 1'b1;
            nRead     <= 1'b1;
            address   <= '0;
            state     <= S_NEXT;
          end else begin
            address <= {SEL_MAIN, OFF_W'(f_src1)};
            nRead   <= 1'b0;
            state   <= S_RD_A;
          end
        end
        S_RD_A: begin
          op_a    <= MemDataOut;
          address <= {SEL_MAIN, OFF_W'(r_src2)};
          state   <= S_RD_B;
        end
        S_RD_B: begin
          op_b  <= MemDataOut;
          nRead <= 1'b1;
          state <= S_WR_A;
        end
        S_WR_A: begin
          address    <= {alu_sel, OFF_W'(0)};
          nWrite     <= 1'b0;
          ExeDataOut <= a_drv;
          state      <= S_WR_B;
        end
        S_WR_B: begin
          address    <= {alu_sel, OFF_W'(1)};
          nWrite     <= 1'b0;
          ExeDataOut <= b_drv;
          wait_cnt   <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          nWrite <= 1'b1;
          if (AluDone) begin
            result <= r_int ? (IntDataOut & INT_MASK) : MatrixDataOut;
            state  <= S_WB;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th consecutive WAIT cycle without AluDone.
            TimedOut <= 1'b1;
            state    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          address     <= {SEL_MAIN, OFF_W'(r_dest)};
          nWrite      <= 1'b0;
          ExeDataOut  <= result;
          RetireCount <= RetireCount + 16'd1;
          state       <= S_NEXT;
        end
        S_NEXT: begin
          nRead      <= 1'b1;
          nWrite     <= 1'b1;
          address    <= '0;
          ExeDataOut <= '0;
          if (slot < SLOT_W'(SLOTS - 1)) begin
            slot  <= slot + 1'b1;
            state <= S_DECODE;
          end else begin
            bundle <= bundle + 1'b1;
            state  <= S_FETCH;
          end
        end
        S_HALT: begin
          Halted     <= 1'b1;
          nRead      <= 1'b1;
          nWrite     <= 1'b1;
          address    <= '0;
          ExeDataOut <= '0;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed vector table, hand-written reset/halt sequences,
// and random programs checked against a transaction-level model of bus activity.
module tb_exec_sequencer;
  localparam int DATA_W  = 256;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 16;
  localparam int SEL_W   = 4;
  localparam int INT_W   = 64;
  localparam int TIMEOUT = 16;
  localparam int SLOTS   = DATA_W / INSTR_W;
  localparam logic [DATA_W-1:0] INT_MASK = DATA_W'({INT_W{1'b1}});

  logic              Clk = 1'b0;
  logic              nReset;
  logic [DATA_W-1:0] InstructDataOut, MemDataOut, MatrixDataOut, IntDataOut;
  logic              AluDone;
  logic [DATA_W-1:0] ExeDataOut;
  logic [ADDR_W-1:0] address;
  logic [7:0]        opcode;
  logic              nRead, nWrite, Halted, IllegalOp, TimedOut;
  logic [15:0]       RetireCount;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  exec_sequencer #(
    .DATA_W(DATA_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W),
    .SEL_W(SEL_W), .INT_W(INT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .nReset(nReset),
    .InstructDataOut(InstructDataOut), .MemDataOut(MemDataOut),
    .MatrixDataOut(MatrixDataOut), .IntDataOut(IntDataOut), .AluDone(AluDone),
    .ExeDataOut(ExeDataOut), .address(address), .opcode(opcode),
    .nRead(nRead), .nWrite(nWrite), .Halted(Halted), .IllegalOp(IllegalOp),
    .TimedOut(TimedOut), .RetireCount(RetireCount)
  );

  // ---------------- memories ----------------
  logic [DATA_W-1:0] imem [0:3];

  function automatic logic [DATA_W-1:0] memval(input logic [11:0] off);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W/32; i++)
      v[i*32 +: 32] = 32'h9E3779B9 * (32'(off) + 32'd1) + 32'(i) * 32'h01000193;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always_comb InstructDataOut = imem[address[1:0]];
  always_comb MemDataOut      = memval(address[11:0]);

  // ---------------- ALU driver ----------------
  // Each legal instruction consumes one entry of dly_q when its second operand
  // write is seen: N>0 raises AluDone in the N-th WAIT cycle, 0 means never.
  typedef struct { logic [DATA_W-1:0] mat; logic [DATA_W-1:0] iv; } res_t;
  int   dly_q[$];
  res_t res_q[$];
  int   w = 0;
  bit   noise = 1'b0;

  always @(negedge Clk) begin
    MatrixDataOut = rand256();
    IntDataOut    = rand256();
    if (!nReset) begin
      w = 0;
      AluDone = 1'b0;
    end else begin
      if (!nWrite && (address == 16'h2001 || address == 16'h3001))
        w = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
      else if (w > 0)
        w--;
      if (w == 1) begin
        res_t r;
        r.mat = MatrixDataOut;
        r.iv  = IntDataOut;
        AluDone = 1'b1;
        res_q.push_back(r);
      end else begin
        AluDone = (w == 0 && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  typedef struct { bit wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] dat; } ev_t;
  ev_t act_q[$];
  int  both_low = 0;

  always @(negedge Clk) begin
    if (nReset) begin
      ev_t e;
      if (!nRead && !nWrite) both_low++;
      if (!nRead) begin
        e.wr = 1'b0; e.addr = address; e.dat = '0;
        act_q.push_back(e);
      end
      if (!nWrite) begin
        e.wr = 1'b1; e.addr = address; e.dat = ExeDataOut;
        act_q.push_back(e);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit wr; bit wb; bit is_int;
    logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] dat;
  } xev_t;
  xev_t exp_q[$];
  int   exp_edges, exp_ret;
  bit   exp_ill, exp_to;
  int   prog_dl[$];

  function automatic xev_t xe(input bit wr, input bit wb, input bit ii,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    xev_t x;
    x.wr = wr; x.wb = wb; x.is_int = ii; x.addr = a; x.dat = d;
    return x;
  endfunction

  // Walks the program in execution order and lists every bus strobe it must produce.
  task automatic build_model();
    int dl[$];
    bit done;
    dl = prog_dl;
    exp_q.delete();
    exp_edges = 0; exp_ret = 0; exp_ill = 1'b0; exp_to = 1'b0; done = 1'b0;
    for (int b = 0; b < 4 && !done; b++) begin
      exp_q.push_back(xe(1'b0, 1'b0, 1'b0, 16'h1000 | 16'(b), '0));
      exp_edges += 2;
      for (int s = 0; s < SLOTS && !done; s++) begin
        logic [31:0] ins;
        logic [7:0]  op, de, s1, s2;
        bit          im, ii;
        ins = imem[b][s*32 +: 32];
        op = ins[31:24]; de = ins[23:16]; s1 = ins[15:8]; s2 = ins[7:0];
        im = (op <= 8'h05);
        ii = (op >= 8'h10 && op <= 8'h13);
        if (op == 8'hFF) begin
          exp_edges += 2;
          done = 1'b1;
        end else if (!im && !ii) begin
          exp_ill = 1'b1;
          exp_edges += 2;
        end else begin
          int d;
          logic [3:0] sel;
          logic [DATA_W-1:0] a, bb;
          d   = (dl.size() > 0) ? dl.pop_front() : 0;
          sel = ii ? 4'h3 : 4'h2;
          a   = ii ? (memval(12'(s1)) & INT_MASK) : memval(12'(s1));
          bb  = (op == 8'h05) ? DATA_W'(s2) : (ii ? (memval(12'(s2)) & INT_MASK) : memval(12'(s2)));
          exp_q.push_back(xe(1'b0, 1'b0, 1'b0, {8'h00, s1}, '0));
          exp_q.push_back(xe(1'b0, 1'b0, 1'b0, {8'h00, s2}, '0));
          exp_q.push_back(xe(1'b1, 1'b0, 1'b0, {sel, 12'h000}, a));
          exp_q.push_back(xe(1'b1, 1'b0, 1'b0, {sel, 12'h001}, bb));
          if (d == 0) begin
            exp_to = 1'b1;
            exp_edges += 5 + TIMEOUT + 1;
            done = 1'b1;
          end else begin
            exp_q.push_back(xe(1'b1, 1'b1, ii, {8'h00, de}, '0));
            exp_ret++;
            exp_edges += 7 + d;
          end
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s want %s", name, got, want);
    end
  endtask

  task automatic check_reset(input string tag);
    chk(address == '0 && nRead && nWrite && ExeDataOut == '0 && opcode == 8'h00,
        {tag, "_bus"},
        $sformatf("addr=%h nRead=%b nWrite=%b exe=%h op=%h", address, nRead, nWrite, ExeDataOut, opcode),
        "addr=0 nRead=1 nWrite=1 exe=0 op=0");
    chk(!Halted && !IllegalOp && !TimedOut && RetireCount == 16'd0,
        {tag, "_flags"},
        $sformatf("halt=%b ill=%b to=%b ret=%0d", Halted, IllegalOp, TimedOut, RetireCount),
        "halt=0 ill=0 to=0 ret=0");
  endtask

  task automatic run_check(input string tag, input bit nz, input int tbl_edges);
    int edges;
    bit hit, quiet;
    build_model();
    nReset = 1'b0;
    dly_q = prog_dl;
    res_q.delete();
    act_q.delete();
    both_low = 0;
    noise = nz;
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    edges = 0; hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      edges++;
      if (Halted) hit = 1'b1;
    end
    if (tbl_edges >= 0)
      chk(edges == tbl_edges, {tag, "_cycles"}, $sformatf("%0d", edges), $sformatf("%0d", tbl_edges));
    chk(edges == exp_edges, {tag, "_model_cycles"}, $sformatf("%0d", edges), $sformatf("%0d", exp_edges));
    quiet = 1'b1;
    repeat (12) begin
      @(negedge Clk);
      if (!(Halted && nRead && nWrite && address == '0)) quiet = 1'b0;
    end
    chk(quiet, {tag, "_halt_quiet"}, $sformatf("%b", quiet), "1");
    chk(RetireCount == 16'(exp_ret) && IllegalOp == exp_ill && TimedOut == exp_to,
        {tag, "_status"},
        $sformatf("ret=%0d ill=%b to=%b", RetireCount, IllegalOp, TimedOut),
        $sformatf("ret=%0d ill=%b to=%b", exp_ret, exp_ill, exp_to));
    chk(act_q.size() == exp_q.size(), {tag, "_nevents"},
        $sformatf("%0d", act_q.size()), $sformatf("%0d", exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      logic [DATA_W-1:0] want;
      bit ok;
      want = exp_q[i].dat;
      ok = 1'b1;
      if (exp_q[i].wb) begin
        if (res_q.size() == 0) ok = 1'b0;
        else begin
          res_t r;
          r = res_q.pop_front();
          want = exp_q[i].is_int ? (r.iv & INT_MASK) : r.mat;
        end
      end
      ok = ok && act_q[i].wr == exp_q[i].wr && act_q[i].addr == exp_q[i].addr &&
           (!exp_q[i].wr || act_q[i].dat == want);
      chk(ok, $sformatf("%s_ev%0d", tag, i),
          $sformatf("wr=%b addr=%h dat=%h", act_q[i].wr, act_q[i].addr, act_q[i].dat),
          $sformatf("wr=%b addr=%h dat=%h", exp_q[i].wr, exp_q[i].addr, want));
    end
    chk(both_low == 0, {tag, "_strobe_excl"}, $sformatf("%0d", both_low), "0");
  endtask

  task automatic clear_imem();
    for (int b = 0; b < 4; b++) imem[b] = {SLOTS{32'hFF000000}};
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    logic [7:0] op;
    r = $urandom_range(0, 9);
    if (r < 5) op = 8'($urandom_range(0, 5));
    else if (r < 8) op = 8'($urandom_range(16, 19));
    else begin
      op = 8'($urandom_range(0, 254));
      while (op <= 8'h05 || (op >= 8'h10 && op <= 8'h13)) op = 8'($urandom_range(0, 254));
    end
    return op;
  endfunction

  // ---------------- directed table ----------------
  typedef struct { logic [31:0] ins; int d; int edges; int ret; bit ill; bit to; } vec_t;
  vec_t tbl[10];

  initial begin
    bit hit;
    nReset = 1'b1; AluDone = 1'b0; MatrixDataOut = '0; IntDataOut = '0;
    tbl[0] = '{32'h01050102, 3, 14, 1, 1'b0, 1'b0};  // MAdd, 3 WAIT cycles
    tbl[1] = '{32'h05070309, 1,  12, 1, 1'b0, 1'b0}; // MScaleImm
    tbl[2] = '{32'h10060102, 2,  13, 1, 1'b0, 1'b0}; // IntAdd
    tbl[3] = '{32'h03040506, 1,  12, 1, 1'b0, 1'b0}; // MTranspose still reads both
    tbl[4] = '{32'h13AA0B0C, 4,  15, 1, 1'b0, 1'b0}; // IntDiv
    tbl[5] = '{32'h42010203, 0,   6, 0, 1'b1, 1'b0}; // illegal
    tbl[6] = '{32'h06010203, 0,   6, 0, 1'b1, 1'b0}; // just past matrix range
    tbl[7] = '{32'h14010203, 0,   6, 0, 1'b1, 1'b0}; // just past int range
    tbl[8] = '{32'h00010203, 0,  24, 0, 1'b0, 1'b1}; // AluDone never: timeout
    tbl[9] = '{32'hFF000000, 0,   4, 0, 1'b0, 1'b0}; // STOP first

    // Reset values, first fetch, and reset while WR_B is on the bus.
    clear_imem();
    imem[0][31:0] = 32'h01050102;
    dly_q.push_back(5);
    #1 nReset = 1'b0;
    #1 check_reset("reset_init");
    @(negedge Clk);
    nReset = 1'b1;
    @(posedge Clk);
    #1;
    chk(address == 16'h1000 && !nRead && nWrite, "first_fetch",
        $sformatf("addr=%h nRead=%b nWrite=%b", address, nRead, nWrite), "addr=1000 nRead=0 nWrite=1");
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge Clk);
      if (!nWrite && address == 16'h2001) hit = 1'b1;
    end
    chk(hit, "reach_wr_b", $sformatf("%b", hit), "1");
    #1 nReset = 1'b0;
    #1 check_reset("reset_mid_wrb");
    @(negedge Clk);
    nReset = 1'b1;
    @(posedge Clk);
    #1;
    chk(address == 16'h1000 && !nRead && nWrite, "refetch_after_reset",
        $sformatf("addr=%h nRead=%b nWrite=%b", address, nRead, nWrite), "addr=1000 nRead=0 nWrite=1");

    for (int i = 0; i < 10; i++) begin
      clear_imem();
      imem[0][31:0] = tbl[i].ins;
      prog_dl.delete();
      if (tbl[i].ret == 1 || tbl[i].to) prog_dl.push_back(tbl[i].d);
      run_check($sformatf("vec%0d", i), 1'b0, tbl[i].edges);
      chk(RetireCount == 16'(tbl[i].ret) && IllegalOp == tbl[i].ill && TimedOut == tbl[i].to && Halted,
          $sformatf("vec%0d_table_status", i),
          $sformatf("ret=%0d ill=%b to=%b halt=%b", RetireCount, IllegalOp, TimedOut, Halted),
          $sformatf("ret=%0d ill=%b to=%b halt=1", tbl[i].ret, tbl[i].ill, tbl[i].to));
    end

    // Full bundle of legal ops, then STOP in slot 3 of bundle 1.
    clear_imem();
    imem[0] = {32'h13161710, 32'h10150D0E, 32'h05140B0C, 32'h04130901,
               32'h03120708, 32'h02110506, 32'h00100304, 32'h01050102};
    imem[1][127:0] = {32'hFF000000, 32'h00220506, 32'h12210304, 32'h11200102};
    prog_dl.delete();
    repeat (11) prog_dl.push_back(1);
    run_check("two_bundles", 1'b0, 94);

    // Random programs with AluDone noise outside WAIT.
    for (int p = 0; p < 5; p++) begin
      int nb, ss;
      clear_imem();
      prog_dl.delete();
      nb = $urandom_range(1, 3);
      ss = $urandom_range(0, SLOTS - 1);
      for (int b = 0; b < nb; b++) begin
        for (int s = 0; s < SLOTS; s++) begin
          logic [7:0] op;
          if (b == nb - 1 && s >= ss) begin
            imem[b][s*32 +: 32] = 32'hFF000000;
          end else begin
            op = rand_op();
            imem[b][s*32 +: 32] = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
            if (op <= 8'h05 || (op >= 8'h10 && op <= 8'h13))
              prog_dl.push_back($urandom_range(1, 4));
          end
        end
      end
      run_check($sformatf("rand%0d", p), 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
